// File: rtl/counter_sched.sv
// Round-robin owner of one shared enable-driven up-counter. Each granted
// requester gets a counting window of its own length, followed by a
// single-cycle completion pulse.
module counter_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  input  logic                  abort,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  cnt_en,
  output logic [WIDTH-1:0]      cnt_val,
  output logic [NREQ-1:0]       done
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;    // last granted requester
  logic [IW-1:0]    idx_q, idx_d;    // owner of the current window
  logic [WIDTH-1:0] len_q, len_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;

  logic             win_vld;
  logic [IW-1:0]    win_idx;
  logic [NREQ-1:0]  owner_oh;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int unsigned cand;
    logic [IW-1:0] cand_idx;
    win_vld = 1'b0;
    win_idx = ptr_q;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand     = (32'(ptr_q) + k) % NREQ;
      cand_idx = IW'(cand);
      if (!win_vld && req[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  // Next-state logic for the window sequencer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (win_vld && !abort) begin
          idx_d   = win_idx;
          ptr_d   = win_idx;
          len_d   = len[32'(win_idx)*WIDTH +: WIDTH];
          cnt_d   = '0;
          // A zero-length window skips counting and only signals completion.
          state_d = (len_d == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q + WIDTH'(1) == len_q) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + WIDTH'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State and window registers; ptr resets so requester 0 wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= IW'(NREQ - 1);
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode only from flops, so there is no input-to-output path.
  always_comb begin
    owner_oh = NREQ'(1) << idx_q;
    gnt      = (state_q == StRun)  ? owner_oh : '0;
    done     = (state_q == StDone) ? owner_oh : '0;
    busy     = (state_q != StIdle);
    cnt_en   = (state_q == StRun);
    cnt_val  = cnt_q;
  end

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: directed scenarios plus random traffic, all
// compared against a job-timeline model of the scheduler.
module tb_counter_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] len;
  logic                  abort;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  cnt_en;
  logic [WIDTH-1:0]      cnt_val;
  logic [NREQ-1:0]       done;

  counter_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .len     (len),
    .abort   (abort),
    .gnt     (gnt),
    .busy    (busy),
    .cnt_en  (cnt_en),
    .cnt_val (cnt_val),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Job-timeline model: a job granted at edge s with length L counts in
  // periods s..s+L-1, signals done in period s+L and is idle in s+L+1.
  int t;          // index of the most recent clock edge
  bit m_active;
  int m_start;
  int m_len;
  int m_owner;
  int m_next;     // earliest edge at which a new grant may happen
  int m_ptr;

  function automatic logic [31:0] pack_len(input int l0, input int l1, input int l2,
                                           input int l3);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_next   = 0;
    m_ptr    = NREQ - 1;
  endtask

  task automatic model_edge();
    int c;
    t++;
    if (m_active && t >= m_start + m_len + 2) m_active = 1'b0;
    if (m_active && t <= m_start + m_len && abort) begin
      m_active = 1'b0;
      m_next   = t + 1;
    end else if (!m_active && t >= m_next && !abort && req != '0) begin
      for (int k = 1; k <= NREQ; k++) begin
        c = (m_ptr + k) % NREQ;
        if (req[c]) begin
          m_owner  = c;
          m_ptr    = c;
          m_len    = int'(len[c*WIDTH +: WIDTH]);
          m_start  = t;
          m_next   = t + m_len + 2;
          m_active = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    int off;
    logic [NREQ-1:0] e_gnt, e_done;
    logic e_busy, e_en;
    int e_cnt;
    e_gnt = '0; e_done = '0; e_busy = 1'b0; e_en = 1'b0; e_cnt = 0;
    if (m_active) begin
      off = t - m_start;
      if (off < m_len) begin
        e_gnt  = NREQ'(1) << m_owner;
        e_busy = 1'b1;
        e_en   = 1'b1;
        e_cnt  = off;
      end else if (off == m_len) begin
        e_done = NREQ'(1) << m_owner;
        e_busy = 1'b1;
      end
    end
    check_val("gnt", 32'(gnt), 32'(e_gnt));
    check_val("busy", 32'(busy), 32'(e_busy));
    check_val("cnt_en", 32'(cnt_en), 32'(e_en));
    check_val("cnt_val", 32'(cnt_val), 32'(e_cnt));
    check_val("done", 32'(done), 32'(e_done));
  endtask

  // One clock: apply inputs, step model at the edge, compare mid-cycle.
  task automatic cycle(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] l,
                       input logic a);
    req = r; len = l; abort = a;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic do_reset();
    req = '0; len = '0; abort = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    compare_outputs();
    rst = 1'b1;
  endtask

  int n_en;
  int n_done;
  logic [NREQ-1:0] first_gnt;
  logic [NREQ-1:0] r_rand;
  logic [NREQ*WIDTH-1:0] l_rand;

  initial begin
    t = 0;
    m_start = 0; m_len = 0; m_owner = 0;
    model_reset();

    // Single request, length 5.
    do_reset();
    for (int i = 0; i < 7; i++) cycle(4'b0001, pack_len(5, 0, 0, 0), 1'b0);
    for (int i = 0; i < 3; i++) cycle(4'b0000, pack_len(5, 0, 0, 0), 1'b0);

    // Fairness with all requesters asking for length 2.
    do_reset();
    for (int i = 0; i < 20; i++) cycle(4'b1111, pack_len(2, 2, 2, 2), 1'b0);

    // Zero-length window.
    do_reset();
    n_en = 0;
    cycle(4'b0100, pack_len(3, 3, 0, 3), 1'b0);
    check_val("zero_len_done", 32'(done), 32'h4);
    for (int i = 0; i < 4; i++) begin
      cycle(4'b0000, pack_len(3, 3, 0, 3), 1'b0);
      if (cnt_en) n_en++;
    end
    check_val("zero_len_en", 32'(n_en), 32'd0);

    // Abort while cnt_val is 3; next grant must go to requester 1.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(4'b0011, pack_len(10, 3, 0, 0), 1'b0);
    check_val("abort_pre_cnt", 32'(cnt_val), 32'd3);
    cycle(4'b0011, pack_len(10, 3, 0, 0), 1'b1);
    first_gnt = '0;
    for (int i = 0; i < 8; i++) begin
      cycle(4'b0011, pack_len(10, 3, 0, 0), 1'b0);
      if (first_gnt == '0) first_gnt = gnt;
    end
    check_val("abort_next_gnt", 32'(first_gnt), 32'h2);

    // Asynchronous reset in the middle of a window.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(4'b0001, pack_len(10, 4, 0, 0), 1'b0);
    check_val("arst_pre_cnt", 32'(cnt_val), 32'd4);
    #2 rst = 1'b0;
    #1;
    check_val("arst_gnt", 32'(gnt), 32'd0);
    check_val("arst_busy", 32'(busy), 32'd0);
    check_val("arst_en", 32'(cnt_en), 32'd0);
    check_val("arst_cnt", 32'(cnt_val), 32'd0);
    check_val("arst_done", 32'(done), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle(4'b0011, pack_len(3, 3, 0, 0), 1'b0);
    check_val("arst_first_gnt", 32'(gnt), 32'h1);
    for (int i = 0; i < 10; i++) cycle(4'b0011, pack_len(3, 3, 0, 0), 1'b0);

    // Mid-window req drop and len change have no effect.
    do_reset();
    n_en = 0; n_done = 0;
    cycle(4'b0010, pack_len(0, 6, 0, 0), 1'b0);
    if (cnt_en) n_en++;
    for (int i = 0; i < 9; i++) begin
      cycle(4'b0000, pack_len(0, 2, 0, 0), 1'b0);
      if (cnt_en) n_en++;
      if (done == 4'b0010) n_done++;
    end
    check_val("midwin_len", 32'(n_en), 32'd6);
    check_val("midwin_done", 32'(n_done), 32'd1);

    // Random traffic.
    do_reset();
    r_rand = '0;
    l_rand = '0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) r_rand = NREQ'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) l_rand = 32'($urandom) & 32'h0707_0707;
      cycle(r_rand, l_rand, ($urandom_range(0, 24) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
